numbers_scheduler: RTL and testbench

Motion and digit sequencer for the on-screen numbers sprite. Each video frame it computes the sprite position (`x_numbers`, `y_numbers`) and the digit index (`number`) that drive the `graphics` block. It bounces the sprite off the active-area edges and advances the digit on every wall hit. It sits between the VGA sync generator's pixel counters and `graphics`, and updates only at end of frame so a frame is never drawn with mixed positions.

---
 rtl/numbers_scheduler_pkg.sv | 60 ++++++
 rtl/numbers_scheduler_if.sv | 25 ++
 rtl/numbers_frame_tick.sv | 38 +++
 rtl/numbers_scheduler.sv | 126 ++++++++++++
 tb/tb_numbers_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/numbers_scheduler_pkg.sv
// Shared definitions for the numbers sprite: screen geometry, colours, FSM
// states and the per-axis bounce arithmetic.
package numbers_pkg;

  localparam int COORD_W        = 10;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int WIDTH_NUMBERS  = 21;
  localparam int HEIGHT_NUMBERS = 23;

  typedef logic [11:0] colour_t;
  localparam colour_t BLACK  = 12'h000;
  localparam colour_t BLUE   = 12'h00F;
  localparam colour_t GREEN  = 12'h0F0;
  localparam colour_t RED    = 12'hF00;
  localparam colour_t YELLOW = 12'hFF0;
  localparam colour_t WHITE  = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_ARMED
  } sched_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
    logic               hit;
  } axis_result_t;

  // One move along one axis; clamps at 0 and at limit and flips direction there.
  function automatic axis_result_t move_axis(input logic [COORD_W-1:0] pos,
                                             input logic               dir,
                                             input logic [3:0]         speed,
                                             input logic [COORD_W-1:0] limit);
    axis_result_t       res;
    logic signed [10:0] w_sum;
    logic signed [10:0] w_diff;
    w_sum  = $signed({1'b0, pos}) + $signed({7'b0, speed});
    w_diff = $signed({1'b0, pos}) - $signed({7'b0, speed});
    res.pos = pos;
    res.dir = dir;
    res.hit = 1'b0;
    if (dir && (w_sum > $signed({1'b0, limit}))) begin
      res.pos = limit;
      res.dir = 1'b0;
      res.hit = 1'b1;
    end else if (!dir && (w_diff < 11'sd0)) begin
      res.pos = '0;
      res.dir = 1'b1;
      res.hit = 1'b1;
    end else if (dir) begin
      res.pos = w_sum[COORD_W-1:0];
    end else begin
      res.pos = w_diff[COORD_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/numbers_scheduler_if.sv
// Pixel-counter inputs, motion controls and sprite outputs of the scheduler.
interface numbers_if;
  import numbers_pkg::*;

  logic [COORD_W-1:0] x_px;
  logic [COORD_W-1:0] y_px;
  logic               run;
  logic               step;
  logic [COORD_W-1:0] x_numbers;
  logic [COORD_W-1:0] y_numbers;
  logic [2:0]         number;
  logic               hit;
  logic               moving;

  modport master (
    output x_px, y_px, run, step,
    input  x_numbers, y_numbers, number, hit, moving
  );

  modport slave (
    input  x_px, y_px, run, step,
    output x_numbers, y_numbers, number, hit, moving
  );

endinterface

// File: rtl/numbers_frame_tick.sv
// One-cycle pulse when the pixel counters first arrive at the target coordinate;
// holding that coordinate for several clocks still gives a single pulse.
module numbers_frame_tick
  import numbers_pkg::*;
#(
  parameter int X_TARGET = H_ACTIVE - 1,
  parameter int Y_TARGET = V_ACTIVE - 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [COORD_W-1:0] i_x_px,
  input  logic [COORD_W-1:0] i_y_px,
  output logic               o_tick
);

  localparam logic [COORD_W-1:0] X_T = COORD_W'(X_TARGET);
  localparam logic [COORD_W-1:0] Y_T = COORD_W'(Y_TARGET);

  logic [COORD_W-1:0] r_prev_x;
  logic [COORD_W-1:0] r_prev_y;
  logic               w_at_target;
  logic               w_prev_at_target;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_prev_x <= '0;
      r_prev_y <= '0;
    end else begin
      r_prev_x <= i_x_px;
      r_prev_y <= i_y_px;
    end
  end

  assign w_at_target      = (i_x_px == X_T) && (i_y_px == Y_T);
  assign w_prev_at_target = (r_prev_x == X_T) && (r_prev_y == Y_T);
  assign o_tick           = w_at_target && !w_prev_at_target;

endmodule

// File: rtl/numbers_scheduler.sv
// Bounces the numbers sprite around the active area once per frame tick and
// advances the displayed digit on every wall hit; all outputs registered.
module numbers_scheduler
  import numbers_pkg::*;
#(
  parameter int X_INIT          = 100,
  parameter int Y_INIT          = 100,
  parameter int SPEED           = 2,
  parameter int FRAMES_PER_MOVE = 1
) (
  input  logic     clk,
  input  logic     clr,
  numbers_if.slave bus
);

  localparam logic [COORD_W-1:0] X_LIMIT  = COORD_W'(H_ACTIVE - WIDTH_NUMBERS);
  localparam logic [COORD_W-1:0] Y_LIMIT  = COORD_W'(V_ACTIVE - HEIGHT_NUMBERS);
  localparam logic [COORD_W-1:0] X_START  = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y_START  = COORD_W'(Y_INIT);
  localparam logic [3:0]         SPEED_L  = 4'(SPEED);
  localparam logic [7:0]         CNT_LAST = 8'(FRAMES_PER_MOVE - 1);

  sched_state_t       r_state;
  logic [7:0]         r_frame_cnt;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_dx;
  logic               r_dy;
  logic [2:0]         r_number;
  logic               r_hit;
  logic               r_moving;

  logic               w_tick;
  logic               w_move;
  axis_result_t       w_x_res;
  axis_result_t       w_y_res;

  numbers_frame_tick u_frame_tick (
    .clk    (clk),
    .clr    (clr),
    .i_x_px (bus.x_px),
    .i_y_px (bus.y_px),
    .o_tick (w_tick)
  );

  // A stepped move ignores the frame counter; a running move waits for it.
  always_comb begin
    w_move  = 1'b0;
    w_x_res = move_axis(r_x, r_dx, SPEED_L, X_LIMIT);
    w_y_res = move_axis(r_y, r_dy, SPEED_L, Y_LIMIT);
    if (w_tick) begin
      if (r_state == ST_STEP_ARMED)
        w_move = 1'b1;
      else if ((r_state == ST_RUN) && (r_frame_cnt == CNT_LAST))
        w_move = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_x         <= X_START;
      r_y         <= Y_START;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_number    <= '0;
      r_hit       <= 1'b0;
      r_moving    <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (w_move) begin
        r_x  <= w_x_res.pos;
        r_dx <= w_x_res.dir;
        r_y  <= w_y_res.pos;
        r_dy <= w_y_res.dir;
        // A corner hit clamps both axes but counts as one bounce.
        if (w_x_res.hit || w_y_res.hit) begin
          r_hit    <= 1'b1;
          r_number <= r_number + 3'd1;
        end
      end

      unique case (r_state)
        ST_IDLE: begin
          if (bus.run) begin
            r_state     <= ST_RUN;
            r_frame_cnt <= '0;
            r_moving    <= 1'b1;
          end else if (bus.step) begin
            r_state  <= ST_STEP_ARMED;
            r_moving <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_tick)
            r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
          if (!bus.run) begin
            r_state  <= ST_IDLE;
            r_moving <= 1'b0;
          end
        end
        ST_STEP_ARMED: begin
          if (bus.run) begin
            r_state     <= ST_RUN;
            r_frame_cnt <= '0;
          end else if (w_tick) begin
            r_state  <= ST_IDLE;
            r_moving <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_numbers = r_x;
  assign bus.y_numbers = r_y;
  assign bus.number    = r_number;
  assign bus.hit       = r_hit;
  assign bus.moving    = r_moving;

endmodule

// File: tb/tb_numbers_scheduler.sv
// Directed bench for numbers_scheduler: three parameterisations share one
// stimulus stream and are checked every cycle against a frame-level model.
module tb_numbers_scheduler;

  logic       clk = 1'b0;
  logic       clrIn = 1'b1;
  logic [9:0] xPx = '0;
  logic [9:0] yPx = '0;
  logic       runIn = 1'b0;
  logic       stepIn = 1'b0;

  int checks = 0;
  int errors = 0;

  // Instance parameters: default, corner start, and slow/fast-step variant.
  int pXI[3]  = '{100, 618, 100};
  int pYI[3]  = '{100, 456, 100};
  int pSp[3]  = '{2, 2, 5};
  int pFpm[3] = '{1, 1, 3};

  numbers_if bus0 ();
  numbers_if bus1 ();
  numbers_if bus2 ();

  assign bus0.x_px = xPx;  assign bus0.y_px = yPx;  assign bus0.run = runIn;  assign bus0.step = stepIn;
  assign bus1.x_px = xPx;  assign bus1.y_px = yPx;  assign bus1.run = runIn;  assign bus1.step = stepIn;
  assign bus2.x_px = xPx;  assign bus2.y_px = yPx;  assign bus2.run = runIn;  assign bus2.step = stepIn;

  numbers_scheduler #(.X_INIT(100), .Y_INIT(100), .SPEED(2), .FRAMES_PER_MOVE(1))
    dut0 (.clk(clk), .clr(clrIn), .bus(bus0));
  numbers_scheduler #(.X_INIT(618), .Y_INIT(456), .SPEED(2), .FRAMES_PER_MOVE(1))
    dut1 (.clk(clk), .clr(clrIn), .bus(bus1));
  numbers_scheduler #(.X_INIT(100), .Y_INIT(100), .SPEED(5), .FRAMES_PER_MOVE(3))
    dut2 (.clk(clk), .clr(clrIn), .bus(bus2));

  int aX[3], aY[3], aNum[3], aHit[3], aMov[3];
  always_comb begin
    aX[0] = int'(bus0.x_numbers); aY[0] = int'(bus0.y_numbers); aNum[0] = int'(bus0.number);
    aHit[0] = int'(bus0.hit); aMov[0] = int'(bus0.moving);
    aX[1] = int'(bus1.x_numbers); aY[1] = int'(bus1.y_numbers); aNum[1] = int'(bus1.number);
    aHit[1] = int'(bus1.hit); aMov[1] = int'(bus1.moving);
    aX[2] = int'(bus2.x_numbers); aY[2] = int'(bus2.y_numbers); aNum[2] = int'(bus2.number);
    aHit[2] = int'(bus2.hit); aMov[2] = int'(bus2.moving);
  end

  always #5 clk = ~clk;

  // Model state: state 0 idle, 1 running, 2 waiting for the step frame.
  int mX[3], mY[3], mNum[3], mDx[3], mDy[3], mHit[3], mSt[3], mFc[3], mMov[3];
  int prevX = 0, prevY = 0;
  bit modelValid = 0;

  task automatic checkOutput(input string name, input int inst, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d at %0t: got %0d, expected %0d", name, inst, $time, actual, expected);
    end
  endtask

  task automatic doMove(input int i);
    bit bounced;
    bounced = 0;
    if (mDx[i] == 1 && mX[i] + pSp[i] > 640 - 21) begin
      mX[i] = 640 - 21; mDx[i] = 0; bounced = 1;
    end else if (mDx[i] == 0 && mX[i] < pSp[i]) begin
      mX[i] = 0; mDx[i] = 1; bounced = 1;
    end else begin
      mX[i] = mX[i] + (mDx[i] == 1 ? pSp[i] : -pSp[i]);
    end
    if (mDy[i] == 1 && mY[i] + pSp[i] > 480 - 23) begin
      mY[i] = 480 - 23; mDy[i] = 0; bounced = 1;
    end else if (mDy[i] == 0 && mY[i] < pSp[i]) begin
      mY[i] = 0; mDy[i] = 1; bounced = 1;
    end else begin
      mY[i] = mY[i] + (mDy[i] == 1 ? pSp[i] : -pSp[i]);
    end
    if (bounced) begin
      mHit[i] = 1;
      mNum[i] = (mNum[i] + 1) % 8;
    end
  endtask

  // Compare what the DUT shows now, then advance the model by the edge to come.
  always @(negedge clk) begin
    bit tick;
    if (modelValid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("x_numbers", i, aX[i], mX[i]);
        checkOutput("y_numbers", i, aY[i], mY[i]);
        checkOutput("number", i, aNum[i], mNum[i]);
        checkOutput("hit", i, aHit[i], mHit[i]);
        checkOutput("moving", i, aMov[i], mMov[i]);
      end
    end
    tick = (xPx == 10'd639 && yPx == 10'd479) && !(prevX == 639 && prevY == 479);
    for (int i = 0; i < 3; i++) begin
      if (clrIn) begin
        mX[i] = pXI[i]; mY[i] = pYI[i]; mNum[i] = 0; mDx[i] = 1; mDy[i] = 1;
        mHit[i] = 0; mSt[i] = 0; mFc[i] = 0;
      end else begin
        mHit[i] = 0;
        case (mSt[i])
          0: begin
            if (runIn) begin mSt[i] = 1; mFc[i] = 0; end
            else if (stepIn) mSt[i] = 2;
          end
          1: begin
            if (tick) begin
              if (mFc[i] == pFpm[i] - 1) begin doMove(i); mFc[i] = 0; end
              else mFc[i]++;
            end
            if (!runIn) mSt[i] = 0;
          end
          default: begin
            if (tick) doMove(i);
            if (runIn) begin mSt[i] = 1; mFc[i] = 0; end
            else if (tick) mSt[i] = 0;
          end
        endcase
      end
      mMov[i] = (mSt[i] != 0) ? 1 : 0;
    end
    if (clrIn) begin
      prevX = 0; prevY = 0; modelValid = 1;
    end else begin
      prevX = int'(xPx); prevY = int'(yPx);
    end
  end

  task automatic applyStimulus(input int xp, input int yp, input bit r, input bit s, input bit c);
    xPx = 10'(xp); yPx = 10'(yp); runIn = r; stepIn = s; clrIn = c;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit r);
    applyStimulus(0, 0, r, 0, 0);
    applyStimulus(639, 479, r, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset_x", 0, aX[0], 100);
    checkOutput("reset_y", 0, aY[0], 100);
    checkOutput("reset_number", 0, aNum[0], 0);
    checkOutput("reset_moving", 0, aMov[0], 0);
    checkOutput("reset_x", 1, aX[1], 618);

    // Idle for three frames: nothing moves.
    for (int f = 0; f < 3; f++) frame(0);
    checkOutput("idle_x", 0, aX[0], 100);
    checkOutput("idle_hit", 0, aHit[0], 0);

    // Run: first move bounces the corner-start instance.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("run_moving", 0, aMov[0], 1);
    frame(1);
    checkOutput("corner_x", 1, aX[1], 619);
    checkOutput("corner_y", 1, aY[1], 457);
    checkOutput("corner_number", 1, aNum[1], 1);
    checkOutput("corner_hit", 1, aHit[1], 1);
    for (int f = 0; f < 4; f++) frame(1);
    checkOutput("run5_x", 0, aX[0], 110);
    checkOutput("run5_y", 0, aY[0], 110);
    checkOutput("run5_x", 1, aX[1], 611);
    checkOutput("run5_x", 2, aX[2], 105);

    // Coordinate held for three clocks gives a single move.
    applyStimulus(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(639, 479, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("hold_x", 0, aX[0], 112);

    // Stop, then idle frames do not move.
    applyStimulus(0, 0, 0, 0, 0);
    frame(0);
    frame(0);
    checkOutput("stop_x", 0, aX[0], 112);
    checkOutput("stop_moving", 0, aMov[0], 0);

    // Single step, with a second step pulse while armed.
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    frame(0);
    frame(0);
    checkOutput("step_x", 0, aX[0], 114);
    checkOutput("step_moving", 0, aMov[0], 0);

    // Step coincident with a tick only arms; move comes on the next frame.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(639, 479, 0, 1, 0);
    checkOutput("step_tick_x", 0, aX[0], 114);
    frame(0);
    checkOutput("step_tick_next_x", 0, aX[0], 116);

    // Run until the digit reaches 7, then reset on a tick cycle.
    applyStimulus(0, 0, 1, 0, 0);
    for (int f = 0; f < 6000 && mNum[0] != 7; f++) frame(1);
    checkOutput("reach7_number", 0, aNum[0], 7);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(639, 479, 1, 0, 1);
    checkOutput("clr_x", 0, aX[0], 100);
    checkOutput("clr_y", 0, aY[0], 100);
    checkOutput("clr_number", 0, aNum[0], 0);
    checkOutput("clr_hit", 0, aHit[0], 0);
    checkOutput("clr_moving", 0, aMov[0], 0);
    applyStimulus(0, 0, 0, 0, 0);
    frame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
